alu_bist: RTL and testbench
===========================

Name: alu_bist

Overview:
- Synthesizable built-in self-test initiator for the 32-bit `alu`.
- Drives the ALU operand and opcode inputs (x, y, op) through an exhaustive small-operand sweep followed by a fixed corner-vector set.
- Samples z, equal, overflow and zero after a settle interval, compares them against an internal reference model, and reports pass/fail, an error count and the first failing vector.
- Sits beside the ALU in the datapath test wrapper, replacing simulation-only stimulus on silicon and FPGA.

Parameters:
- SWEEP_BITS, 5: x and y each sweep 0 .. 2^SWEEP_BITS-1.
- SETTLE_CYCLES, 1: cycles operands are held before sampling ALU outputs; must be ≥1.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a run when idle or done
- busy  out  1  run in progress
- done  out  1  run complete; held until next start
- pass  out  1  done && err_count==0
- alu_x  out  32  ALU operand x
- alu_y  out  32  ALU operand y
- alu_op  out  3  ALU opcode
- alu_z  in  32  ALU result
- alu_equal  in  1  ALU equal flag
- alu_overflow  in  1  ALU overflow flag
- alu_zero  in  1  ALU zero flag
- err_count  out  ERR_W  mismatching vectors, saturating
- first_err_valid  out  1  a mismatch has been captured this run
- first_err_op  out  3  opcode of first mismatch
- first_err_x  out  32  x of first mismatch
- first_err_y  out  32  y of first mismatch
- first_err_z  out  32  alu_z of first mismatch

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low (rst_n). rst_n low at any time, including mid-run, immediately clears all outputs and state to 0 and the FSM to IDLE.
- Opcode map: 000 AND, 001 ADD, 010 SUB, 011 SLT (signed, z = {31'b0, x<y}), 100 SRL, 101 SLL, 110 SRA. Shift amount is y[4:0]. 111 produces z=0.
- Expected flags:
  - equal = (x==y) for every op.
  - zero = (expected z==0).
  - overflow = signed two's-complement overflow for ADD and SUB only; 0 for all other ops.
- FSM states: IDLE → APPLY → WAIT → CHECK → (APPLY | DONE).
  - IDLE/DONE: start=1 → clear err_count and first_err_*; clear done and pass; set busy; go to APPLY.
  - APPLY (1 cycle): register the next vector onto alu_x/alu_y/alu_op; load the settle counter with SETTLE_CYCLES.
  - WAIT: decrement the settle counter; leave when it reaches 0.
  - CHECK (1 cycle): compare all four ALU outputs. Any mismatch increments err_count once per vector (saturates at all-ones). The first mismatch of the run latches first_err_* and sets first_err_valid. If this was the last vector, go to DONE (busy=0, done=1, pass valid); otherwise go to APPLY.
- Cost per vector: 2+SETTLE_CYCLES cycles.
- Vector order:
  - Phase A (sweep): x outer, y middle, op inner, each from 0 upward; x,y zero-extended. That is 2^(2·SWEEP_BITS)·8 vectors.
  - Phase B (corners): op outer 0..7; vector inner, in this order:
    - 0C0000FF/0C0000FF
    - 00000000/00000000
    - FFFFFFFF/FFFFFFFF
    - 55555555/AAAAAAAA
    - 80000006/80000001
    - 80000000/80000000
    - 55555555/7FFFFFFF
    - 80000006/7FFFFFFE
  - That is 64 vectors.
- Defaults: total 8256 vectors; run length 24768 cycles from the first APPLY to the DONE entry.
- start while busy: ignored.
- alu_x/alu_y/alu_op hold their last vector in DONE.

Test Plan:
- Correct ALU model, default params; start pulse → busy for exactly 24768 cycles, then done=1, pass=1, err_count=0, first_err_valid=0.
- ALU fault: op 111 returns z=1 → err_count=1032; first_err op=111, x=0, y=0, z=00000001; pass=0.
- ALU fault: overflow stuck at 0 → err_count=5; first_err op=001, x=80000006, y=80000001.
- ERR_W=4 with the op-111 fault → err_count saturates at 15; done and pass=0 still reached.
- Reset mid-run: rst_n low at cycle 1000 → all outputs 0 asynchronously. A new start afterwards → full 24768-cycle run, pass=1.
- start re-pulsed at cycle 500 while busy → ignored; the run still completes at cycle 24768. A start in DONE clears done, pass and err_count on the next cycle.

Source files
------------

// File: rtl/alu_bist.sv
// Built-in self-test initiator for the 32-bit ALU: sweeps small operands, then corner vectors,
// compares ALU outputs against an internal reference and reports pass/fail and the first failure.
module alu_bist #(
  parameter int unsigned SWEEP_BITS    = 5,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      alu_x,
  output logic [31:0]      alu_y,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_z,
  input  logic             alu_equal,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [2:0]       first_err_op,
  output logic [31:0]      first_err_x,
  output logic [31:0]      first_err_y,
  output logic [31:0]      first_err_z
);

  localparam int unsigned N_SWEEP = 1 << (2 * SWEEP_BITS + 3);
  localparam int unsigned N_VEC   = N_SWEEP + 64;
  localparam int unsigned IDX_W   = $clog2(N_VEC);
  localparam int unsigned SET_W   = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [SET_W-1:0] r_settle;
  logic             r_busy, r_done, r_pass;
  logic [31:0]      r_alu_x, r_alu_y;
  logic [2:0]       r_alu_op;
  logic [ERR_W-1:0] r_err;
  logic             r_fv;
  logic [2:0]       r_fop;
  logic [31:0]      r_fx, r_fy, r_fz;

  logic [5:0]       w_bidx;
  logic [31:0]      w_vx, w_vy;
  logic [2:0]       w_vop;
  logic [31:0]      w_sum, w_dif, w_exp_z;
  logic             w_exp_ov, w_mismatch;

  // Vector generator: index -> (x, y, op); sweep first, then op-major corner table
  always_comb begin
    w_bidx = 6'(r_idx - IDX_W'(N_SWEEP));
    w_vx   = '0;
    w_vy   = '0;
    w_vop  = r_idx[2:0];
    if (r_idx < IDX_W'(N_SWEEP)) begin
      w_vx = 32'(r_idx >> (SWEEP_BITS + 3));
      w_vy = 32'((r_idx >> 3) & IDX_W'((1 << SWEEP_BITS) - 1));
    end else begin
      w_vop = w_bidx[5:3];
      case (w_bidx[2:0])
        3'd0:    begin w_vx = 32'h0C0000FF; w_vy = 32'h0C0000FF; end
        3'd1:    begin w_vx = 32'h00000000; w_vy = 32'h00000000; end
        3'd2:    begin w_vx = 32'hFFFFFFFF; w_vy = 32'hFFFFFFFF; end
        3'd3:    begin w_vx = 32'h55555555; w_vy = 32'hAAAAAAAA; end
        3'd4:    begin w_vx = 32'h80000006; w_vy = 32'h80000001; end
        3'd5:    begin w_vx = 32'h80000000; w_vy = 32'h80000000; end
        3'd6:    begin w_vx = 32'h55555555; w_vy = 32'h7FFFFFFF; end
        default: begin w_vx = 32'h80000006; w_vy = 32'h7FFFFFFE; end
      endcase
    end
  end

  // Reference ALU on the currently applied vector
  always_comb begin
    w_sum    = r_alu_x + r_alu_y;
    w_dif    = r_alu_x - r_alu_y;
    w_exp_ov = 1'b0;
    case (r_alu_op)
      3'd0: w_exp_z = r_alu_x & r_alu_y;
      3'd1: begin
        w_exp_z  = w_sum;
        w_exp_ov = (r_alu_x[31] == r_alu_y[31]) && (w_sum[31] != r_alu_x[31]);
      end
      3'd2: begin
        w_exp_z  = w_dif;
        w_exp_ov = (r_alu_x[31] != r_alu_y[31]) && (w_dif[31] != r_alu_x[31]);
      end
      3'd3:    w_exp_z = {31'b0, $signed(r_alu_x) < $signed(r_alu_y)};
      3'd4:    w_exp_z = r_alu_x >> r_alu_y[4:0];
      3'd5:    w_exp_z = r_alu_x << r_alu_y[4:0];
      3'd6:    w_exp_z = $unsigned($signed(r_alu_x) >>> r_alu_y[4:0]);
      default: w_exp_z = '0;
    endcase
    w_mismatch = (alu_z != w_exp_z)
               || (alu_equal != (r_alu_x == r_alu_y))
               || (alu_overflow != w_exp_ov)
               || (alu_zero != (w_exp_z == 32'd0));
  end

  // Sequencer: apply -> settle -> check per vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_settle <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_alu_x  <= '0;
      r_alu_y  <= '0;
      r_alu_op <= '0;
      r_err    <= '0;
      r_fv     <= 1'b0;
      r_fop    <= '0;
      r_fx     <= '0;
      r_fy     <= '0;
      r_fz     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_err   <= '0;
            r_fv    <= 1'b0;
            r_fop   <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
            r_fz    <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_alu_x  <= w_vx;
          r_alu_y  <= w_vy;
          r_alu_op <= w_vop;
          r_settle <= SET_W'(SETTLE_CYCLES);
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          r_settle <= r_settle - SET_W'(1);
          if (r_settle == SET_W'(1)) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err != '1) r_err <= r_err + ERR_W'(1);
            if (!r_fv) begin
              r_fv  <= 1'b1;
              r_fop <= r_alu_op;
              r_fx  <= r_alu_x;
              r_fy  <= r_alu_y;
              r_fz  <= alu_z;
            end
          end
          if (r_idx == IDX_W'(N_VEC - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err == '0) && !w_mismatch;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= S_APPLY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign alu_x           = r_alu_x;
  assign alu_y           = r_alu_y;
  assign alu_op          = r_alu_op;
  assign err_count       = r_err;
  assign first_err_valid = r_fv;
  assign first_err_op    = r_fop;
  assign first_err_x     = r_fx;
  assign first_err_y     = r_fy;
  assign first_err_z     = r_fz;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: two instances (ERR_W 16 and 4) driven by a fault-injectable ALU model,
// checked every cycle against a vector-list / timeline model of the self-test run.
module tb_alu_bist;

  localparam int NV = 8256;
  localparam int RUN = 3 * NV;
  localparam longint LIM = 64'sd2147483647;

  logic clk, rst_n, start;

  logic        a_busy, a_done, a_pass, a_fv, b_busy, b_done, b_pass, b_fv;
  logic [31:0] a_x, a_y, a_fx, a_fy, a_fz, b_x, b_y, b_fx, b_fy, b_fz;
  logic [2:0]  a_op, a_fop, b_op, b_fop;
  logic [15:0] a_err;
  logic [3:0]  b_err;
  logic [34:0] w_ra, w_rb;
  logic [2:0]  mode_a, mode_b;

  logic [31:0] vx [NV];
  logic [31:0] vy [NV];
  logic [2:0]  vop[NV];
  int          cum[2][NV+1];
  int          first_k[2];
  logic [31:0] first_z[2];
  int          errmax[2];
  logic [31:0] rf_x[20];
  logic [31:0] rf_y[20];
  logic [2:0]  rf_op[20];
  int          rf_n;

  int checks, failures;
  bit m_started;
  int m_n;

  // Plain-arithmetic golden ALU: {z, equal, overflow, zero}
  function automatic logic [34:0] gold(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint s;
    logic [31:0] z;
    logic ov;
    s = 0; z = '0; ov = 1'b0;
    case (op)
      3'd0: z = x & y;
      3'd1: begin s = longint'($signed(x)) + longint'($signed(y)); z = s[31:0]; ov = (s > LIM) || (s < -LIM - 1); end
      3'd2: begin s = longint'($signed(x)) - longint'($signed(y)); z = s[31:0]; ov = (s > LIM) || (s < -LIM - 1); end
      3'd3: z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd4: z = x >> y[4:0];
      3'd5: z = x << y[4:0];
      3'd6: z = $unsigned($signed(x) >>> y[4:0]);
      default: z = '0;
    endcase
    return {z, x == y, ov, z == 32'd0};
  endfunction

  // ALU under test: mode bit0 op111 gives z=1, bit1 overflow stuck 0, bit2 z^1 on listed vectors
  function automatic logic [34:0] faulty(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] mode);
    logic [34:0] r;
    r = gold(op, x, y);
    if (mode[0] && op == 3'd7) begin r[34:3] = 32'd1; r[0] = 1'b0; end
    if (mode[1]) r[1] = 1'b0;
    if (mode[2])
      for (int i = 0; i < rf_n; i++)
        if (rf_x[i] == x && rf_y[i] == y && rf_op[i] == op) begin
          r[34:3] = r[34:3] ^ 32'd1;
          r[0] = (r[34:3] == 32'd0);
        end
    return r;
  endfunction

  assign w_ra = faulty(a_op, a_x, a_y, mode_a);
  assign w_rb = faulty(b_op, b_x, b_y, mode_b);

  alu_bist u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(a_busy), .done(a_done), .pass(a_pass),
    .alu_x(a_x), .alu_y(a_y), .alu_op(a_op), .alu_z(w_ra[34:3]), .alu_equal(w_ra[2]),
    .alu_overflow(w_ra[1]), .alu_zero(w_ra[0]), .err_count(a_err), .first_err_valid(a_fv),
    .first_err_op(a_fop), .first_err_x(a_fx), .first_err_y(a_fy), .first_err_z(a_fz)
  );

  alu_bist #(.SWEEP_BITS(5), .SETTLE_CYCLES(1), .ERR_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(b_busy), .done(b_done), .pass(b_pass),
    .alu_x(b_x), .alu_y(b_y), .alu_op(b_op), .alu_z(w_rb[34:3]), .alu_equal(w_rb[2]),
    .alu_overflow(w_rb[1]), .alu_zero(w_rb[0]), .err_count(b_err), .first_err_valid(b_fv),
    .first_err_op(b_fop), .first_err_x(b_fx), .first_err_y(b_fy), .first_err_z(b_fz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-vector mismatch prefix counts and first failure for one instance
  task automatic build(input int i, input logic [2:0] mode);
    logic [34:0] rg, rfz;
    int c;
    c = 0;
    first_k[i] = -1;
    first_z[i] = '0;
    cum[i][0] = 0;
    for (int k = 0; k < NV; k++) begin
      rg  = gold(vop[k], vx[k], vy[k]);
      rfz = faulty(vop[k], vx[k], vy[k], mode);
      if (rg != rfz) begin
        if (first_k[i] < 0) begin first_k[i] = k; first_z[i] = rfz[34:3]; end
        c++;
      end
      cum[i][k+1] = c;
    end
  endtask

  // Run timeline: m_n counts edges since the accepted start
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 1'b0;
      m_n <= 0;
    end else if (start && (!m_started || m_n >= RUN)) begin
      m_started <= 1'b1;
      m_n <= 0;
    end else if (m_started && m_n < RUN) begin
      m_n <= m_n + 1;
    end
  end

  task automatic chk_inst(input int i, input string p, input logic busy, input logic done, input logic pass,
                          input logic [31:0] x, input logic [31:0] y, input logic [2:0] op,
                          input logic [31:0] err, input logic fv, input logic [2:0] fop,
                          input logic [31:0] fx, input logic [31:0] fy, input logic [31:0] fz);
    int kd, kb, ce, fk;
    bit efv, edone;
    kd = m_started ? m_n / 3 : 0;
    kb = (m_n == 0) ? -1 : (((m_n - 1) / 3 > NV - 1) ? NV - 1 : (m_n - 1) / 3);
    ce = (cum[i][kd] > errmax[i]) ? errmax[i] : cum[i][kd];
    fk = first_k[i];
    efv = (fk >= 0) && (fk < kd);
    edone = m_started && (m_n >= RUN);
    chk({p, ".busy"}, 32'(busy), 32'(m_started && (m_n < RUN)));
    chk({p, ".done"}, 32'(done), 32'(edone));
    chk({p, ".pass"}, 32'(pass), 32'(edone && cum[i][NV] == 0));
    chk({p, ".err_count"}, err, 32'(ce));
    chk({p, ".first_valid"}, 32'(fv), 32'(efv));
    chk({p, ".first_op"}, 32'(fop), efv ? 32'(vop[fk]) : 32'd0);
    chk({p, ".first_x"}, fx, efv ? vx[fk] : 32'd0);
    chk({p, ".first_y"}, fy, efv ? vy[fk] : 32'd0);
    chk({p, ".first_z"}, fz, efv ? first_z[i] : 32'd0);
    if (!m_started) begin
      chk({p, ".alu_x"}, x, 32'd0);
      chk({p, ".alu_y"}, y, 32'd0);
      chk({p, ".alu_op"}, 32'(op), 32'd0);
    end else if (kb >= 0) begin
      chk({p, ".alu_x"}, x, vx[kb]);
      chk({p, ".alu_y"}, y, vy[kb]);
      chk({p, ".alu_op"}, 32'(op), 32'(vop[kb]));
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk_inst(0, "A", a_busy, a_done, a_pass, a_x, a_y, a_op, 32'(a_err), a_fv, a_fop, a_fx, a_fy, a_fz);
    chk_inst(1, "B", b_busy, b_done, b_pass, b_x, b_y, b_op, 32'(b_err), b_fv, b_fop, b_fx, b_fy, b_fz);
  end

  task automatic reroll();
    int idx;
    rf_n = $urandom_range(0, 20);
    for (int i = 0; i < rf_n; i++) begin
      idx = $urandom_range(0, NV - 1);
      rf_x[i] = vx[idx]; rf_y[i] = vy[idx]; rf_op[i] = vop[idx];
    end
  endtask

  task automatic launch(input logic [2:0] ma, input logic [2:0] mb, input bit new_list);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    mode_a = ma;
    mode_b = mb;
    if (new_list) reroll();
    build(0, ma);
    build(1, mb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("launch.busy", 32'(a_busy), 32'd1);
    chk("launch.done_cleared", 32'(a_done), 32'd0);
    chk("launch.pass_cleared", 32'(a_pass), 32'd0);
    chk("launch.err_cleared", 32'(a_err), 32'd0);
  endtask

  // Wait for done with a cycle budget, re-pulsing start while busy
  task automatic wait_done(input int p1, input int p2, output int bcnt, output bit ok);
    bcnt = 1;
    ok = 1'b0;
    for (int c = 1; c <= RUN + 20; c++) begin
      @(negedge clk);
      start = (c == p1) || (c == p2);
      if (a_busy) bcnt++;
      if (a_done) begin ok = 1'b1; break; end
    end
    start = 1'b0;
    chk("run_reached_done", 32'(ok), 32'd1);
  endtask

  task automatic chk_zero();
    chk("rst.A.busy", 32'(a_busy), 32'd0);
    chk("rst.A.done", 32'(a_done), 32'd0);
    chk("rst.A.err", 32'(a_err), 32'd0);
    chk("rst.A.first_valid", 32'(a_fv), 32'd0);
    chk("rst.A.first_z", a_fz, 32'd0);
    chk("rst.A.alu_x", a_x, 32'd0);
    chk("rst.A.alu_op", 32'(a_op), 32'd0);
    chk("rst.B.busy", 32'(b_busy), 32'd0);
    chk("rst.B.err", 32'(b_err), 32'd0);
    chk("rst.B.alu_y", b_y, 32'd0);
  endtask

  initial begin
    logic [31:0] cx[8];
    logic [31:0] cy[8];
    logic [34:0] g;
    int k, bcnt;
    bit ok;
    checks = 0; failures = 0;
    start = 1'b0; rst_n = 1'b1; mode_a = '0; mode_b = '0; rf_n = 0;
    errmax[0] = 65535; errmax[1] = 15;
    cx = '{32'h0C0000FF, 32'h00000000, 32'hFFFFFFFF, 32'h55555555,
           32'h80000006, 32'h80000000, 32'h55555555, 32'h80000006};
    cy = '{32'h0C0000FF, 32'h00000000, 32'hFFFFFFFF, 32'hAAAAAAAA,
           32'h80000001, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFE};
    k = 0;
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        for (int op = 0; op < 8; op++) begin
          vx[k] = 32'(x); vy[k] = 32'(y); vop[k] = 3'(op); k++;
        end
    for (int op = 0; op < 8; op++)
      for (int j = 0; j < 8; j++) begin
        vx[k] = cx[j]; vy[k] = cy[j]; vop[k] = 3'(op); k++;
      end
    build(0, 3'd0);
    build(1, 3'd0);
    #1 rst_n = 1'b0;

    // Hand-computed pins on the golden model
    g = gold(3'd1, 32'h80000006, 32'h80000001);
    chk("gold.add_ovf_z", g[34:3], 32'h00000007);
    chk("gold.add_ovf_flags", 32'(g[2:0]), 32'b010);
    g = gold(3'd2, 32'h55555555, 32'hAAAAAAAA);
    chk("gold.sub_ovf_z", g[34:3], 32'hAAAAAAAB);
    chk("gold.sub_ovf_flag", 32'(g[1]), 32'd1);
    g = gold(3'd3, 32'h80000006, 32'h7FFFFFFE);
    chk("gold.slt_signed", g[34:3], 32'd1);
    g = gold(3'd6, 32'h80000000, 32'h0000001F);
    chk("gold.sra", g[34:3], 32'hFFFFFFFF);
    g = gold(3'd4, 32'h80000000, 32'h0000001F);
    chk("gold.srl", g[34:3], 32'h00000001);
    g = gold(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("gold.op7_flags", 32'(g), {29'd0, 3'b101});

    repeat (3) @(negedge clk);
    chk_zero();
    rst_n = 1'b1;

    // Run 1: clean ALU on A, random vector faults on B, start re-pulsed while busy
    launch(3'd0, 3'd4, 1'b1);
    wait_done(500, $urandom_range(600, RUN - 50), bcnt, ok);
    chk("run1.busy_cycles", 32'(bcnt), 32'(RUN));
    chk("run1.pass", 32'(a_pass), 32'd1);
    chk("run1.err", 32'(a_err), 32'd0);
    chk("run1.first_valid", 32'(a_fv), 32'd0);

    // Run 2: op111 fault, reset at cycle 1000, then a full run
    launch(3'd1, 3'd1, 1'b0);
    chk("model.op7_count", 32'(cum[0][NV]), 32'd1032);
    repeat (999) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_zero();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    launch(3'd1, 3'd1, 1'b0);
    wait_done(-1, $urandom_range(10, RUN - 50), bcnt, ok);
    chk("run2.busy_cycles", 32'(bcnt), 32'(RUN));
    chk("run2.err", 32'(a_err), 32'd1032);
    chk("run2.first_op", 32'(a_fop), 32'd7);
    chk("run2.first_x", a_fx, 32'd0);
    chk("run2.first_y", a_fy, 32'd0);
    chk("run2.first_z", a_fz, 32'h00000001);
    chk("run2.pass", 32'(a_pass), 32'd0);
    chk("run2.B_sat", 32'(b_err), 32'd15);
    chk("run2.B_done", 32'(b_done), 32'd1);
    chk("run2.B_pass", 32'(b_pass), 32'd0);

    // Run 3: overflow stuck at 0 on A, fresh random faults on B
    launch(3'd2, 3'd4, 1'b1);
    chk("model.ovf_count", 32'(cum[0][NV]), 32'd5);
    wait_done($urandom_range(2, 400), $urandom_range(401, RUN - 50), bcnt, ok);
    chk("run3.err", 32'(a_err), 32'd5);
    chk("run3.first_op", 32'(a_fop), 32'd1);
    chk("run3.first_x", a_fx, 32'h80000006);
    chk("run3.first_y", a_fy, 32'h80000001);
    chk("run3.first_z", a_fz, 32'h00000007);
    chk("run3.pass", 32'(a_pass), 32'd0);
    chk("run3.hold_x", a_x, 32'h80000006);
    chk("run3.hold_op", 32'(a_op), 32'd7);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
